// File: rtl/apu_irq_ctrl_pkg.sv
// Shared definitions for the APU interrupt controller: register word offsets and widths.
// No logic; no latency.
// No flow control.
package apu_irq_ctrl_pkg;

    localparam int MAX_IRQ    = 31;
    localparam int CLAIM_ID_W = 8;

    // Word index = byte offset >> 2 (haddr[4:2])
    localparam logic [2:0] REG_PEND  = 3'd0;
    localparam logic [2:0] REG_EN    = 3'd1;
    localparam logic [2:0] REG_CLAIM = 3'd2;
    localparam logic [2:0] REG_FORCE = 3'd3;
    localparam logic [2:0] REG_MODE  = 3'd4;

    typedef struct packed {
        logic       vld;
        logic       write;
        logic [2:0] idx;
    } dphase_t;

endpackage

// File: rtl/apu_irq_ctrl_prio.sv
// Lowest-index-wins priority encoder: ID = index+1 (0 = none) plus a one-hot grant.
// Purely combinational, zero latency.
// No flow control.
module apu_irq_ctrl_prio #(
    parameter int N_IRQ = 8,
    parameter int W_ID  = 8
) (
    input  logic [N_IRQ-1:0] req,
    output logic [W_ID-1:0]  id,
    output logic [N_IRQ-1:0] gnt
);

    // Scan downward so the lowest set index is the final assignment.
    always_comb begin
        id  = '0;
        gnt = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                id     = W_ID'(i + 1);
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apu_irq_ctrl.sv
// APU interrupt controller: edge-latched pending bits, enable mask, claim register on AHB-Lite; APU_IRQ_CTRL_LEVEL_EN adds per-source level mode.
// Edge to irq_out: 2 cycles; bus reads combinational in the data phase, writes applied at its end.
// Never stalls: hready_resp tied high, hresp tied low.
module apu_irq_ctrl
    import apu_irq_ctrl_pkg::*;
#(
    parameter int N_IRQ = 8,
    parameter int W_ID  = CLAIM_ID_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      ahbls_haddr,
    input  logic [1:0]       ahbls_htrans,
    input  logic             ahbls_hwrite,
    input  logic [2:0]       ahbls_hsize,
    input  logic             ahbls_hready,
    output logic             ahbls_hready_resp,
    input  logic [31:0]      ahbls_hwdata,
    output logic [31:0]      ahbls_hrdata,
    output logic             ahbls_hresp,
    input  logic [N_IRQ-1:0] irq_in,
    output logic             irq_out
);

    dphase_t          dph_q;
    logic [N_IRQ-1:0] pend_q, en_q, irq_prev_q;
    logic [N_IRQ-1:0] eff_pend, level_msk, req;
    logic [N_IRQ-1:0] claim_gnt, set_vec, w1c_vec, force_vec, claim_clr, pend_d;
    logic [W_ID-1:0]  claim_id;
    logic             addr_acc, wr_dp, rd_dp;
    logic             unused_bits;

    assign ahbls_hready_resp = 1'b1;
    assign ahbls_hresp       = 1'b0;
    assign unused_bits = ^{ahbls_haddr[15:5], ahbls_haddr[1:0], ahbls_htrans[0],
                           ahbls_hwdata[31:N_IRQ]};

    assign addr_acc = ahbls_hready & ahbls_htrans[1];

    // Non-word accesses still complete, but never reach the registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dph_q <= '0;
        end else begin
            dph_q <= '{vld:   addr_acc && (ahbls_hsize == 3'd2),
                       write: ahbls_hwrite,
                       idx:   ahbls_haddr[4:2]};
        end
    end

    assign wr_dp = dph_q.vld &  dph_q.write;
    assign rd_dp = dph_q.vld & ~dph_q.write;

`ifdef APU_IRQ_CTRL_LEVEL_EN
    logic [N_IRQ-1:0] mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
        end else if (wr_dp && dph_q.idx == REG_MODE) begin
            mode_q <= ahbls_hwdata[N_IRQ-1:0];
        end
    end

    assign level_msk = mode_q;
`else
    assign level_msk = '0;
`endif

    // Level sources bypass the pending flop and follow the wire directly.
    assign eff_pend = (pend_q & ~level_msk) | (irq_in & level_msk);
    assign req      = eff_pend & en_q;

    apu_irq_ctrl_prio #(
        .N_IRQ (N_IRQ),
        .W_ID  (W_ID)
    ) u_prio (
        .req (req),
        .id  (claim_id),
        .gnt (claim_gnt)
    );

    assign set_vec   = irq_in & ~irq_prev_q;
    assign w1c_vec   = (wr_dp && dph_q.idx == REG_PEND)  ? ahbls_hwdata[N_IRQ-1:0] : '0;
    assign force_vec = (wr_dp && dph_q.idx == REG_FORCE) ? ahbls_hwdata[N_IRQ-1:0] : '0;
    assign claim_clr = (rd_dp && dph_q.idx == REG_CLAIM) ? claim_gnt : '0;
    assign pend_d    = ((pend_q & ~(w1c_vec | claim_clr)) | set_vec | force_vec) & ~level_msk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            en_q       <= '0;
            irq_prev_q <= '0;
            irq_out    <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            irq_prev_q <= irq_in;
            irq_out    <= |req;
            if (wr_dp && dph_q.idx == REG_EN) begin
                en_q <= ahbls_hwdata[N_IRQ-1:0];
            end
        end
    end

    always_comb begin
        ahbls_hrdata = '0;
        if (rd_dp) begin
            case (dph_q.idx)
                REG_PEND:  ahbls_hrdata[N_IRQ-1:0] = eff_pend;
                REG_EN:    ahbls_hrdata[N_IRQ-1:0] = en_q;
                REG_CLAIM: ahbls_hrdata[W_ID-1:0]  = claim_id;
                REG_MODE:  ahbls_hrdata[N_IRQ-1:0] = level_msk;
                default:   ahbls_hrdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apu_irq_ctrl.sv
// Self-checking bench for apu_irq_ctrl: register table, hand-written corner sequences,
// then randomized bus/irq traffic against a cycle-level reference model.
module tb_apu_irq_ctrl;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic          hready;
    logic          hready_resp;
    logic [31:0]   hwdata;
    logic [31:0]   hrdata;
    logic          hresp;
    logic [N-1:0]  irq_in;
    logic          irq_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    apu_irq_ctrl #(.N_IRQ(N), .W_ID(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ahbls_haddr       (haddr),
        .ahbls_htrans      (htrans),
        .ahbls_hwrite      (hwrite),
        .ahbls_hsize       (hsize),
        .ahbls_hready      (hready),
        .ahbls_hready_resp (hready_resp),
        .ahbls_hwdata      (hwdata),
        .ahbls_hrdata      (hrdata),
        .ahbls_hresp       (hresp),
        .irq_in            (irq_in),
        .irq_out           (irq_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        irq_in = '0;
        haddr  = '0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'd2;
        hready = 1'b1;
        hwdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns in the data phase; the next clock edge completes the transfer.
    task automatic bus(input logic [15:0] a, input logic w, input logic [2:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd);
        @(posedge clk); #1;
        haddr  = a;
        htrans = 2'b10;
        hwrite = w;
        hsize  = sz;
        hready = 1'b1;
        @(posedge clk); #1;
        htrans = 2'b00;
        hwrite = 1'b0;
        hwdata = wd;
        rd     = hrdata;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic [15:0] a, input logic w, input logic [2:0] sz,
                                input logic [31:0] wd, input logic [31:0] exp, input string nm);
        vec_t v;
        v.addr = a; v.wr = w; v.sz = sz; v.wd = wd; v.exp = exp; v.name = nm;
        vt.push_back(v);
    endfunction

    // Reference model state: one entry per source.
    bit m_pend[N], m_en[N], m_mode[N], m_prev[N];
    bit m_irq, m_dv, m_dw;
    int m_idx;

    function automatic bit m_eff(input int i);
        return m_mode[i] ? irq_in[i] : m_pend[i];
    endfunction

    function automatic int m_claim();
        for (int i = 0; i < N; i++)
            if (m_eff(i) && m_en[i]) return i + 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_read();
        logic [31:0] r = '0;
        if (!m_dv || m_dw) return '0;
        for (int i = 0; i < N; i++) begin
            if (m_idx == 0 && m_eff(i)) r = r + (32'd1 << i);
            if (m_idx == 1 && m_en[i])  r = r + (32'd1 << i);
`ifdef APU_IRQ_CTRL_LEVEL_EN
            if (m_idx == 4 && m_mode[i]) r = r + (32'd1 << i);
`endif
        end
        if (m_idx == 2) r = 32'(m_claim());
        return r;
    endfunction

    task automatic m_step();
        int  id;
        bit  nirq;
        bit  old_mode[N];
        id   = m_claim();
        nirq = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_eff(i) && m_en[i]) nirq = 1'b1;
            old_mode[i] = m_mode[i];
        end
        if (m_dv && m_dw) begin
            for (int i = 0; i < N; i++) begin
                if (m_idx == 0 && hwdata[i]) m_pend[i] = 1'b0;
                if (m_idx == 1) m_en[i] = hwdata[i];
`ifdef APU_IRQ_CTRL_LEVEL_EN
                if (m_idx == 4) m_mode[i] = hwdata[i];
`endif
            end
        end
        if (m_dv && !m_dw && m_idx == 2 && id != 0) m_pend[id-1] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (irq_in[i] && !m_prev[i]) m_pend[i] = 1'b1;
            if (m_dv && m_dw && m_idx == 3 && hwdata[i]) m_pend[i] = 1'b1;
            if (old_mode[i]) m_pend[i] = 1'b0;
            m_prev[i] = irq_in[i];
        end
        m_irq = nirq;
        m_dv  = hready && htrans[1] && (hsize == 3'd2);
        m_dw  = hwrite;
        m_idx = int'(haddr[4:2]);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] rd;

        do_reset();
        chk("reset_irq_out", 32'(irq_out), 32'd0);
        chk("reset_hrdata", hrdata, 32'd0);
        chk("reset_hready_resp", 32'(hready_resp), 32'd1);
        chk("reset_hresp", 32'(hresp), 32'd0);

        // Register table, applied in order from reset with irq_in idle
        add(16'h00, 0, 2, 0, 32'h00, "tbl_pend_rst");
        add(16'h04, 0, 2, 0, 32'h00, "tbl_en_rst");
        add(16'h08, 0, 2, 0, 32'h00, "tbl_claim_rst");
        add(16'h0C, 0, 2, 0, 32'h00, "tbl_force_raz");
        add(16'h04, 1, 2, 32'h0F, 32'h00, "tbl_wr_en");
        add(16'h04, 0, 2, 0, 32'h0F, "tbl_rd_en");
        add(16'h0C, 1, 0, 32'hFF, 32'h00, "tbl_force_byte");
        add(16'h00, 0, 2, 0, 32'h00, "tbl_pend_after_byte");
        add(16'h0C, 1, 1, 32'hFF, 32'h00, "tbl_force_half");
        add(16'h00, 0, 2, 0, 32'h00, "tbl_pend_after_half");
        add(16'h0C, 1, 2, 32'h30, 32'h00, "tbl_force_30");
        add(16'h00, 0, 2, 0, 32'h30, "tbl_pend_30");
        add(16'h08, 0, 2, 0, 32'h00, "tbl_claim_masked");
        add(16'h04, 1, 2, 32'hFF, 32'h00, "tbl_en_ff");
        add(16'h08, 0, 2, 0, 32'h05, "tbl_claim_5");
        add(16'h08, 0, 2, 0, 32'h06, "tbl_claim_6");
        add(16'h08, 0, 2, 0, 32'h00, "tbl_claim_none");
        add(16'h08, 1, 2, 32'hFF, 32'h00, "tbl_claim_wi");
        add(16'h00, 0, 2, 0, 32'h00, "tbl_pend_empty");
        add(16'h04, 0, 2, 0, 32'hFF, "tbl_en_kept");
        add(16'h0C, 1, 2, 32'h81, 32'h00, "tbl_force_81");
        add(16'h00, 1, 2, 32'h01, 32'h00, "tbl_w1c_01");
        add(16'h00, 0, 2, 0, 32'h80, "tbl_pend_80");
        add(16'h00, 1, 0, 32'h80, 32'h00, "tbl_w1c_byte");
        add(16'h00, 0, 2, 0, 32'h80, "tbl_pend_still_80");
        add(16'h00, 0, 0, 0, 32'h00, "tbl_pend_byte_read");
        add(16'h14, 0, 2, 0, 32'h00, "tbl_raz_14");
        add(16'h18, 1, 2, 32'hFF, 32'h00, "tbl_wi_18");
        add(16'h1C, 0, 2, 0, 32'h00, "tbl_raz_1c");
        add(16'h10, 1, 2, 32'hFF, 32'h00, "tbl_wr_mode");
`ifdef APU_IRQ_CTRL_LEVEL_EN
        add(16'h10, 0, 2, 0, 32'hFF, "tbl_rd_mode");
`else
        add(16'h10, 0, 2, 0, 32'h00, "tbl_rd_mode");
`endif
        add(16'h10, 1, 2, 32'h00, 32'h00, "tbl_clr_mode");

        foreach (vt[k]) begin
            bus(vt[k].addr, vt[k].wr, vt[k].sz, vt[k].wd, rd);
            chk(vt[k].name, rd, vt[k].exp);
            chk("tbl_hready_resp", 32'(hready_resp), 32'd1);
            chk("tbl_hresp", 32'(hresp), 32'd0);
        end

        // Single edge: 2-cycle irq latency, claim, clear
        do_reset();
        bus(16'h04, 1, 2, 32'h05, rd);
        idle(1);
        irq_in = 8'h04;
        idle(1);
        irq_in = 8'h00;
        chk("edge_irq_lat1", 32'(irq_out), 32'd0);
        idle(1);
        chk("edge_irq_lat2", 32'(irq_out), 32'd1);
        bus(16'h00, 0, 2, 0, rd);
        chk("edge_pend", rd, 32'h04);
        bus(16'h08, 0, 2, 0, rd);
        chk("edge_claim", rd, 32'd3);
        bus(16'h00, 0, 2, 0, rd);
        chk("edge_pend_cleared", rd, 32'h00);
        chk("edge_irq_drop", 32'(irq_out), 32'd0);

        // Successive claims in priority order
        do_reset();
        bus(16'h04, 1, 2, 32'hFF, rd);
        idle(1);
        irq_in = 8'h52;
        idle(1);
        irq_in = 8'h00;
        idle(1);
        bus(16'h08, 0, 2, 0, rd); chk("prio_claim_a", rd, 32'd2);
        bus(16'h08, 0, 2, 0, rd); chk("prio_claim_b", rd, 32'd5);
        bus(16'h08, 0, 2, 0, rd); chk("prio_claim_c", rd, 32'd7);
        bus(16'h08, 0, 2, 0, rd); chk("prio_claim_d", rd, 32'd0);

        // New edge in the same cycle as W1C: set wins
        do_reset();
        bus(16'h0C, 1, 2, 32'h01, rd);
        idle(1);
        haddr = 16'h00; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        idle(1);
        htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h01; irq_in = 8'h01;
        idle(1);
        bus(16'h00, 0, 2, 0, rd);
        chk("setwins_pend", rd, 32'h01);
        bus(16'h00, 1, 2, 32'h01, rd);
        idle(1);
        bus(16'h00, 0, 2, 0, rd);
        chk("setwins_second_w1c", rd, 32'h00);
        irq_in = 8'h00;

        // FORCE sizes and masked pending
        do_reset();
        bus(16'h04, 1, 2, 32'h7F, rd);
        bus(16'h0C, 1, 0, 32'hFF, rd);
        bus(16'h00, 0, 2, 0, rd);
        chk("force_byte_pend", rd, 32'h00);
        bus(16'h0C, 1, 2, 32'h80, rd);
        idle(2);
        chk("force_masked_irq", 32'(irq_out), 32'd0);
        bus(16'h00, 0, 2, 0, rd);
        chk("force_word_pend", rd, 32'h80);
        bus(16'h04, 1, 2, 32'hFF, rd);
        idle(2);
        chk("reenable_irq", 32'(irq_out), 32'd1);

`ifdef APU_IRQ_CTRL_LEVEL_EN
        // Level-triggered source follows the wire; claims do not clear it
        do_reset();
        bus(16'h10, 1, 2, 32'h08, rd);
        bus(16'h04, 1, 2, 32'h08, rd);
        irq_in = 8'h08;
        idle(2);
        bus(16'h08, 0, 2, 0, rd); chk("level_claim_a", rd, 32'd4);
        bus(16'h08, 0, 2, 0, rd); chk("level_claim_b", rd, 32'd4);
        bus(16'h00, 0, 2, 0, rd); chk("level_pend", rd, 32'h08);
        idle(1);
        chk("level_irq_high", 32'(irq_out), 32'd1);
        irq_in = 8'h00;
        idle(1);
        chk("level_irq_low", 32'(irq_out), 32'd0);
        bus(16'h00, 0, 2, 0, rd); chk("level_pend_low", rd, 32'h00);
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_en[i] = 0; m_mode[i] = 0; m_prev[i] = 0;
        end
        m_irq = 0; m_dv = 0; m_dw = 0; m_idx = 0;
        for (int c = 0; c < 4000; c++) begin
            irq_in = irq_in ^ N'($urandom & $urandom & $urandom);
            hready = ($urandom_range(0, 7) != 0);
            htrans = 2'($urandom);
            hwrite = 1'($urandom);
            hsize  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
            haddr  = (16'($urandom) & 16'hFFE0) | 16'($urandom_range(0, 7) * 4);
            hwdata = $urandom & $urandom;
            #1;
            chk("rnd_hrdata", hrdata, m_read());
            chk("rnd_irq_out", 32'(irq_out), 32'(m_irq));
            chk("rnd_hready_resp", 32'(hready_resp), 32'd1);
            chk("rnd_hresp", 32'(hresp), 32'd0);
            m_step();
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
